// File: rtl/sdram_pkg.sv
// Shared types and pure helpers for the SDRAM power-up sequence monitor.
// Covers the command and error enums, the FSM state type, and the pin/mode decoding functions.
package sdram_pkg;

  typedef enum logic [3:0] {
    NOP = 4'd0,
    ACT = 4'd1,
    RD  = 4'd2,
    WR  = 4'd3,
    BST = 4'd4,
    PRE = 4'd5,
    REF = 4'd6,
    LMR = 4'd7,
    INH = 4'd8
  } cmd_e;

  typedef enum logic [2:0] {
    NONE        = 3'd0,
    EARLY_CMD   = 3'd1,
    TIMING      = 3'd2,
    SEQ         = 3'd3,
    PRE_NOT_ALL = 3'd4,
    BAD_MODE    = 3'd5
  } err_e;

  typedef enum logic [2:0] {
    PWRUP,
    WAIT_PRE,
    TRP,
    WAIT_REF,
    TRFC,
    TMRD,
    DONE,
    ERR
  } state_e;

  // A deselected chip or a stopped clock makes every other pin meaningless.
  function automatic cmd_e decode_cmd(input logic cke, input logic cs_n,
                                      input logic ras_n, input logic cas_n,
                                      input logic we_n);
    cmd_e c;
    c = NOP;
    if (!cke || cs_n) begin
      c = INH;
    end else begin
      case ({ras_n, cas_n, we_n})
        3'b111:  c = NOP;
        3'b011:  c = ACT;
        3'b101:  c = RD;
        3'b100:  c = WR;
        3'b110:  c = BST;
        3'b010:  c = PRE;
        3'b001:  c = REF;
        default: c = LMR;
      endcase
    end
    return c;
  endfunction

  function automatic logic [3:0] burst_len_of(input logic [2:0] code);
    logic [3:0] bl;
    case (code)
      3'd0:    bl = 4'd1;
      3'd1:    bl = 4'd2;
      3'd2:    bl = 4'd4;
      3'd3:    bl = 4'd8;
      default: bl = 4'd0;
    endcase
    return bl;
  endfunction

  // Burst codes 4..6 are reserved; only CAS latencies 2 and 3 are supported.
  function automatic logic mode_ok(input logic [11:0] m);
    logic cl_ok;
    logic bl_ok;
    cl_ok = (m[5:4] == 2'd2) || (m[5:4] == 2'd3);
    bl_ok = (m[2:0] <= 3'd3) || (m[2:0] == 3'd7);
    return cl_ok && bl_ok;
  endfunction

endpackage

// File: rtl/sdram_cmd_decode.sv
// Pin-level SDRAM command decoder.
// The raw decode feeds the sequence FSM; a registered copy is exposed on the bus-monitor outputs.
module sdram_cmd_decode
  import sdram_pkg::*;
(
  input  logic sclk,
  input  logic srst_n,
  input  logic cke,
  input  logic cs_n,
  input  logic ras_n,
  input  logic cas_n,
  input  logic we_n,
  output cmd_e cur_cmd,
  output cmd_e cmd,
  output logic cmd_valid
);

  assign cur_cmd = decode_cmd(cke, cs_n, ras_n, cas_n, we_n);

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) begin
      cmd       <= NOP;
      cmd_valid <= 1'b0;
    end else begin
      cmd       <= cur_cmd;
      cmd_valid <= (cur_cmd != NOP) && (cur_cmd != INH);
    end
  end

endmodule

// File: rtl/sdram_init_monitor.sv
// Passive checker for the SDRAM power-up sequence:
// power-up wait -> PRECHARGE ALL -> N x AUTO REFRESH -> LOAD MODE, latching the first violation.
module sdram_init_monitor
  import sdram_pkg::*;
#(
  parameter int T_POWERUP = 10000,
  parameter int T_RP      = 2,
  parameter int T_RFC     = 4,
  parameter int T_MRD     = 2,
  parameter int N_REFRESH = 2
) (
  input  logic        sclk,
  input  logic        srst_n,
  input  logic        cke,
  input  logic        cs_n,
  input  logic        ras_n,
  input  logic        cas_n,
  input  logic        we_n,
  input  logic [1:0]  ba,
  input  logic [11:0] addr,
  output logic        cmd_valid,
  output logic [3:0]  cmd,
  output logic        init_done,
  output logic [11:0] mode_reg,
  output logic [3:0]  burst_len,
  output logic [1:0]  cas_lat,
  output logic        err,
  output logic [2:0]  err_code
);

  localparam int TW = $clog2(T_POWERUP + 1);

  // Wait states expire on the cycle the timer reads 1, so a load of T-1 leaves
  // exactly T cycles between the triggering command and the next legal one.
  localparam logic [TW-1:0] PWR_LOAD = TW'(T_POWERUP);
  localparam logic [TW-1:0] RP_LOAD  = TW'(T_RP - 1);
  localparam logic [TW-1:0] RFC_LOAD = TW'(T_RFC - 1);
  localparam logic [TW-1:0] MRD_LOAD = TW'(T_MRD - 1);
  localparam logic [TW-1:0] TIMER_ONE = TW'(1);
  localparam logic [3:0]    N_REF    = 4'(N_REFRESH);

  cmd_e cur_cmd;
  cmd_e cmd_q;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    ref_cnt_q, ref_cnt_d;
  logic          err_hit;
  err_e          err_kind;
  err_e          err_code_q;
  logic          is_cmd;
  logic          timer_expired;
  logic          bus_unused;

  // Bank bits carry no meaning for any init-sequence check.
  assign bus_unused = ^ba;

  sdram_cmd_decode u_decode (
    .sclk      (sclk),
    .srst_n    (srst_n),
    .cke       (cke),
    .cs_n      (cs_n),
    .ras_n     (ras_n),
    .cas_n     (cas_n),
    .we_n      (we_n),
    .cur_cmd   (cur_cmd),
    .cmd       (cmd_q),
    .cmd_valid (cmd_valid)
  );

  assign cmd      = cmd_q;
  assign err_code = err_code_q;

  assign is_cmd        = (cur_cmd != NOP) && (cur_cmd != INH);
  assign timer_expired = (timer_q <= TIMER_ONE);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    ref_cnt_d = ref_cnt_q;
    err_hit   = 1'b0;
    err_kind  = NONE;

    case (state_q)
      PWRUP: begin
        if (is_cmd) begin
          err_hit  = 1'b1;
          err_kind = EARLY_CMD;
        end else if (!cke) begin
          timer_d = PWR_LOAD;
        end else if (timer_expired) begin
          state_d = WAIT_PRE;
          timer_d = '0;
        end else begin
          timer_d = timer_q - TIMER_ONE;
        end
      end

      WAIT_PRE: begin
        if (is_cmd) begin
          if (cur_cmd != PRE) begin
            err_hit  = 1'b1;
            err_kind = SEQ;
          end else if (!addr[10]) begin
            err_hit  = 1'b1;
            err_kind = PRE_NOT_ALL;
          end else begin
            state_d = TRP;
            timer_d = RP_LOAD;
          end
        end
      end

      TRP, TRFC, TMRD: begin
        // A command on the expiry cycle is still early: timing wins.
        if (is_cmd) begin
          err_hit  = 1'b1;
          err_kind = TIMING;
        end else if (timer_expired) begin
          state_d = (state_q == TMRD) ? DONE : WAIT_REF;
          timer_d = '0;
        end else begin
          timer_d = timer_q - TIMER_ONE;
        end
      end

      WAIT_REF: begin
        if (cur_cmd == REF) begin
          state_d = TRFC;
          timer_d = RFC_LOAD;
          if (ref_cnt_q != 4'hF) ref_cnt_d = ref_cnt_q + 4'd1;
        end else if (cur_cmd == LMR && ref_cnt_q >= N_REF) begin
          if (mode_ok(addr)) begin
            state_d = TMRD;
            timer_d = MRD_LOAD;
          end else begin
            err_hit  = 1'b1;
            err_kind = BAD_MODE;
          end
        end else if (is_cmd) begin
          err_hit  = 1'b1;
          err_kind = SEQ;
        end
      end

      DONE: begin
        if (cur_cmd == LMR && !mode_ok(addr)) begin
          err_hit  = 1'b1;
          err_kind = BAD_MODE;
        end
      end

      default: ;
    endcase

    if (err_hit) state_d = ERR;
  end

  // Timer is preloaded so the power-up count starts on the first cycle out of reset.
  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) begin
      state_q    <= PWRUP;
      timer_q    <= PWR_LOAD;
      ref_cnt_q  <= '0;
      err        <= 1'b0;
      err_code_q <= NONE;
      init_done  <= 1'b0;
      mode_reg   <= '0;
      burst_len  <= '0;
      cas_lat    <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      ref_cnt_q <= ref_cnt_d;
      if (err_hit && !err) begin
        err        <= 1'b1;
        err_code_q <= err_kind;
      end
      if (state_q == DONE) init_done <= 1'b1;
      if (cur_cmd == LMR) begin
        mode_reg  <= addr;
        burst_len <= burst_len_of(addr[2:0]);
        cas_lat   <= addr[5:4];
      end
    end
  end

endmodule
